rat_intr_ctrl: RTL and testbench
================================

# rat_intr_ctrl

Interrupt controller for the RAT MCU. It sits between up to eight interrupt sources (keypad driver, debounced buttons, timers) and the MCU's single `interrupt` input. It latches source edges, arbitrates among pending sources and drives a fixed-width interrupt pulse. It then holds off further interrupts until the ISR acknowledges through an output port. The ISR identifies the source and masks sources through the same port bus the wrapper's I/O muxes use.

## Interface
Parameters:
- `NUM_SRC`, 4: number of sources, 1..8.
- `ID_PORT`, 8'h90: read port; returns active source byte.
- `PEND_PORT`, 8'h91: read port; returns pending vector, zero-extended.
- `MASK_PORT`, 8'h92: read/write port for the enable mask; bit=1 means enabled.
- `ACK_PORT`, 8'h93: write port; any write ends service.
- `PULSE_CYCLES`, 4: width of the `interrupt` pulse in `clk` cycles, 1..15.

Ports:
- `clk`, in, 1: single clock, MCU I/O clock domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `src_req`, in, NUM_SRC: source request lines, asynchronous, rising-edge significant.
- `port_id`, in, 8: MCU port address.
- `out_port`, in, 8: MCU write data.
- `io_strb`, in, 1: MCU write strobe.
- `rd_data`, out, 8: read data for the wrapper input mux. It is 8'h00 when `port_id` matches no read port.
- `rd_hit`, out, 1: high combinationally when `port_id` equals `ID_PORT`, `PEND_PORT` or `MASK_PORT`.
- `interrupt`, out, 1: registered interrupt pulse to the MCU.
- `busy`, out, 1: high in every state other than IDLE.

## Operation
Input capture:
- Each `src_req[i]` passes through a 2-flop synchronizer and then a previous-value register.
- A rising edge sets `pend[i]`.
- Further edges while `pend[i]` is set are absorbed. There is no counting.

Arbitration:
- Eligible sources are `pend & mask`.
- The default is fixed priority: the lowest index wins.

FSM states:
- IDLE: when any source is eligible, grant the winner and go to ASSERT. On the same edge:
  - latch its index into `act_id`;
  - clear its `pend` bit;
  - load the pulse counter with `PULSE_CYCLES`;
  - set `interrupt`.
- ASSERT: `interrupt`=1. The counter decrements each cycle. When it reaches 1:
  - clear `interrupt`;
  - go to WAIT_ACK, or to IDLE if an ack was recorded during ASSERT.
- WAIT_ACK: `interrupt`=0. A write to `ACK_PORT` (`io_strb`=1) returns the FSM to IDLE. There is no timeout.

Register writes:
- `MASK_PORT` write: `mask <= out_port[NUM_SRC-1:0]` on the next edge, in any state.
- `ACK_PORT` write in IDLE is ignored.
- Write data for `ACK_PORT` is ignored.

Reads:
- `ID_PORT` returns `{busy, 4'b0, act_id[2:0]}`. `act_id` holds its last value after service ends.
- `PEND_PORT` returns `pend`.
- `MASK_PORT` returns `mask`.

Masked sources still latch `pend`. They are granted once unmasked.

## Timing
Reset values (asynchronous on `reset_n`=0):
- FSM in IDLE; `pend`=0; `mask` all ones; `act_id`=0.
- Synchronizer and edge flops cleared.
- `interrupt`=0, `busy`=0.
- Reset mid-pulse or mid-service drops `interrupt` immediately and discards pending requests.

Latency:
- `src_req` rises before edge k. `pend` sets at edge k+2. Grant and `interrupt`=1 occur at edge k+3.
- `interrupt` is high for exactly `PULSE_CYCLES` cycles.
- After an ack in WAIT_ACK at edge a, the FSM is IDLE after a. The next grant can occur at edge a+1.
- Minimum back-to-back spacing is `PULSE_CYCLES`+2 cycles, with ack issued in the first WAIT_ACK cycle.

Simultaneous events:
- An edge on the active source during its service sets `pend` again. It is granted after the ack.
- Edge set and grant-clear on the same bit in the same cycle: the set wins.
- A mask write and a grant on the same edge: the grant uses the old mask.

`rd_data` and `rd_hit` are purely combinational from `port_id` and registers.

## Configuration
- `INTC_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The search starts at index `(last_grant+1) mod NUM_SRC`.
  - `last_grant` resets to `NUM_SRC-1`, so the first search starts at 0.
- Not defined: fixed priority, lowest index wins. No `last_grant` register is built.

## Test plan
- Reset, then read ports -> `ID_PORT`=8'h00, `PEND_PORT`=8'h00, `MASK_PORT`=8'h0F, `interrupt`=0.
- Pulse `src_req[2]` -> `interrupt` high 3 edges later for 4 cycles. `ID_PORT`=8'h82. Ack -> `busy`=0, `ID_PORT`=8'h02.
- Raise `src_req[1]` and `src_req[3]` together. Fixed build: grants 1, then 3 after ack. Round-robin with `last_grant`=1: grants 3 first.
- Write `MASK_PORT`=8'h0E, pulse `src_req[0]` -> no interrupt, `PEND_PORT`=8'h01. Write 8'h0F -> grant 0.
- Ack during ASSERT -> FSM returns to IDLE right after the pulse, skipping WAIT_ACK. An `ACK_PORT` write in IDLE -> no state change.
- Assert `reset_n`=0 mid-pulse -> `interrupt` drops without a clock edge. After release, `pend`=0 and no interrupt occurs.

Source files
------------

// File: rtl/rat_intr_ctrl.sv
// rat_intr_ctrl: RAT MCU interrupt controller; define INTC_ROUND_ROBIN_EN for round-robin arbitration
module rat_intr_ctrl #(
    parameter int         NUM_SRC      = 4,
    parameter logic [7:0] ID_PORT      = 8'h90,
    parameter logic [7:0] PEND_PORT    = 8'h91,
    parameter logic [7:0] MASK_PORT    = 8'h92,
    parameter logic [7:0] ACK_PORT     = 8'h93,
    parameter int         PULSE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               io_strb,
    output logic [7:0]         rd_data,
    output logic               rd_hit,
    output logic               interrupt,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK} state_t;
    state_t state, state_n;
    logic [NUM_SRC-1:0] sync1, sync2, prev, pend, mask, elig, grant_clr;
    logic [3:0] cnt, cnt_n;
    logic [2:0] act_id, act_id_n, gnt_id;
    logic ack_seen, ack_seen_n, gnt_valid, ack_wr, mask_wr;

    assign ack_wr  = io_strb && port_id == ACK_PORT;
    assign mask_wr = io_strb && port_id == MASK_PORT;
    assign elig    = pend & mask;
    assign busy    = state != IDLE;

`ifdef INTC_ROUND_ROBIN_EN
    logic [2:0] last_grant;
    int best, dist;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) last_grant <= 3'(NUM_SRC - 1);
        else if (state == IDLE && gnt_valid) last_grant <= gnt_id;
    // dist is each slot's position in the search order starting after last_grant
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id = '0;
        best = NUM_SRC;
        dist = 0;
        for (int j = 0; j < NUM_SRC; j++) begin
            dist = (j + 2 * NUM_SRC - int'(last_grant) - 1) % NUM_SRC;
            if (elig[j] && dist < best) begin
                best = dist;
                gnt_valid = 1'b1;
                gnt_id = 3'(j);
            end
        end
    end
`else
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                gnt_valid = 1'b1;
                gnt_id = 3'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            pend  <= '0;
            mask  <= '1;
        end else begin
            sync1 <= src_req;
            sync2 <= sync1;
            prev  <= sync2;
            // a fresh edge overrides the grant clear on the same bit
            pend  <= (pend & ~grant_clr) | (sync2 & ~prev);
            mask  <= mask_wr ? NUM_SRC'(out_port) : mask;
        end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        act_id_n = act_id;
        ack_seen_n = ack_seen;
        grant_clr = '0;
        case (state)
            IDLE: if (gnt_valid) begin
                state_n = ASSERT;
                cnt_n = 4'(PULSE_CYCLES);
                act_id_n = gnt_id;
                ack_seen_n = 1'b0;
                grant_clr = NUM_SRC'(1) << gnt_id;
            end
            ASSERT: begin
                ack_seen_n = ack_seen | ack_wr;
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = (ack_seen | ack_wr) ? IDLE : WAIT_ACK;
            end
            WAIT_ACK: state_n = ack_wr ? IDLE : WAIT_ACK;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            act_id    <= '0;
            ack_seen  <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            act_id    <= act_id_n;
            ack_seen  <= ack_seen_n;
            interrupt <= state_n == ASSERT;
        end

    assign rd_hit  = port_id == ID_PORT || port_id == PEND_PORT || port_id == MASK_PORT;
    assign rd_data = port_id == ID_PORT   ? {busy, 4'b0, act_id} :
                     port_id == PEND_PORT ? 8'(pend) :
                     port_id == MASK_PORT ? 8'(mask) : 8'h00;
endmodule

// File: tb/tb_rat_intr_ctrl.sv
// tb_rat_intr_ctrl: directed bench for rat_intr_ctrl with a cycle-numbered service model
module tb_rat_intr_ctrl;
    localparam int NS = 4;
    localparam int P = 4;
    localparam logic [7:0] IDP = 8'h90, PDP = 8'h91, MKP = 8'h92, AKP = 8'h93;

    logic clk = 1'b0, reset_n = 1'b1, io_strb = 1'b0;
    logic rd_hit, interrupt, busy;
    logic [NS-1:0] src_req = '0;
    logic [7:0] port_id = 8'h00, out_port = 8'h00, rd_data;
    int tests = 0, fails = 0;

    rat_intr_ctrl dut (
        .clk(clk), .reset_n(reset_n), .src_req(src_req), .port_id(port_id),
        .out_port(out_port), .io_strb(io_strb), .rd_data(rd_data), .rd_hit(rd_hit),
        .interrupt(interrupt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: a request is scheduled to become pending two edges after it is sampled;
    // a grant at edge g keeps the line high until edge g+P.
    logic [NS-1:0] m_pend = '0, m_mask = '1, m_prev = '0;
    int set_at [NS];
    int cyc = 0, g_cyc = 0, m_act = 0, m_last = NS - 1, w;
    bit serving = 0, waiting = 0, acked = 0, m_ack;
    logic [7:0] m_rd;
    bit m_hit;

    function automatic int pick();
        logic [NS-1:0] e;
        e = m_pend & m_mask;
`ifdef INTC_ROUND_ROBIN_EN
        for (int k = 1; k <= NS; k++) if (e[(m_last + k) % NS]) return (m_last + k) % NS;
`else
        for (int i = 0; i < NS; i++) if (e[i]) return i;
`endif
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; m_pend = '0; m_mask = '1; m_prev = '0; m_act = 0; m_last = NS - 1;
            serving = 0; waiting = 0; acked = 0;
            for (int i = 0; i < NS; i++) set_at[i] = -1;
        end else begin
            cyc++;
            m_ack = io_strb && port_id == AKP;
            if (serving) begin
                acked = acked | m_ack;
                if (cyc == g_cyc + P) begin
                    serving = 0;
                    waiting = !acked;
                end
            end else if (waiting) begin
                if (m_ack) waiting = 0;
            end else begin
                w = pick();
                if (w >= 0) begin
                    serving = 1; g_cyc = cyc; acked = 0; m_act = w; m_last = w;
                    m_pend[w] = 1'b0;
                end
            end
            for (int i = 0; i < NS; i++) if (set_at[i] == cyc) begin m_pend[i] = 1'b1; set_at[i] = -1; end
            for (int i = 0; i < NS; i++) if (src_req[i] && !m_prev[i]) set_at[i] = cyc + 2;
            m_prev = src_req;
            if (io_strb && port_id == MKP) m_mask = out_port[NS-1:0];
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        m_hit = port_id == IDP || port_id == PDP || port_id == MKP;
        m_rd = port_id == IDP ? {serving || waiting, 4'b0, 3'(m_act)} :
               port_id == PDP ? 8'(m_pend) :
               port_id == MKP ? 8'(m_mask) : 8'h00;
        chk("mon_interrupt", {7'b0, interrupt}, {7'b0, serving});
        chk("mon_busy", {7'b0, busy}, {7'b0, serving || waiting});
        chk("mon_rd_hit", {7'b0, rd_hit}, {7'b0, m_hit});
        chk("mon_rd_data", rd_data, m_rd);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id = p; out_port = d; io_strb = 1'b1;
        tick(1);
        io_strb = 1'b0; port_id = 8'h00; out_port = 8'h00;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] p, input logic [7:0] exp);
        port_id = p;
        #1;
        chk(name, rd_data, exp);
        port_id = 8'h00;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        tick(1);
        rd_chk("rst_id", IDP, 8'h00);
        rd_chk("rst_pend", PDP, 8'h00);
        rd_chk("rst_mask", MKP, 8'h0F);
        chk("rst_int", {7'b0, interrupt}, 8'h00);
        port_id = AKP;
        #1;
        chk("ack_port_no_hit", {7'b0, rd_hit}, 8'h00);
        chk("ack_port_rd_zero", rd_data, 8'h00);
        port_id = 8'h00;

        src_req = 4'b0100; tick(1); src_req = '0;
        tick(1); chk("lat_k1_int", {7'b0, interrupt}, 8'h00);
        tick(1); chk("lat_k2_int", {7'b0, interrupt}, 8'h00); rd_chk("lat_k2_pend", PDP, 8'h04);
        tick(1); chk("lat_k3_int", {7'b0, interrupt}, 8'h01);
        rd_chk("src2_id", IDP, 8'h82); rd_chk("src2_pend_clr", PDP, 8'h00);
        tick(3); chk("pulse_last", {7'b0, interrupt}, 8'h01);
        tick(1); chk("pulse_end", {7'b0, interrupt}, 8'h00); chk("wait_busy", {7'b0, busy}, 8'h01);
        rd_chk("wait_id", IDP, 8'h82);
        wr(AKP, 8'h55);
        chk("ack_busy", {7'b0, busy}, 8'h00); rd_chk("ack_id", IDP, 8'h02);

        src_req = 4'b1010; tick(1); src_req = '0;
        tick(3); chk("pair_int1", {7'b0, interrupt}, 8'h01);
`ifdef INTC_ROUND_ROBIN_EN
        rd_chk("pair_first", IDP, 8'h83);
`else
        rd_chk("pair_first", IDP, 8'h81);
`endif
        tick(4); wr(AKP, 8'h00);
        tick(1); chk("pair_int2", {7'b0, interrupt}, 8'h01);
`ifdef INTC_ROUND_ROBIN_EN
        rd_chk("pair_second", IDP, 8'h81);
`else
        rd_chk("pair_second", IDP, 8'h83);
`endif
        tick(4); wr(AKP, 8'h00);

        wr(MKP, 8'h0E); rd_chk("mask_0e", MKP, 8'h0E);
        src_req = 4'b0001; tick(1); src_req = '0;
        tick(4); chk("masked_no_int", {7'b0, interrupt}, 8'h00); rd_chk("masked_pend", PDP, 8'h01);
        wr(MKP, 8'h0F); chk("mask_wr_old_mask", {7'b0, interrupt}, 8'h00);
        tick(1); chk("unmask_grant", {7'b0, interrupt}, 8'h01); rd_chk("unmask_id", IDP, 8'h80);

        wr(AKP, 8'h00);
        tick(2); chk("early_ack_still_high", {7'b0, interrupt}, 8'h01);
        tick(1); chk("early_ack_int", {7'b0, interrupt}, 8'h00); chk("early_ack_idle", {7'b0, busy}, 8'h00);
        wr(AKP, 8'h00); tick(2);
        chk("idle_ack_busy", {7'b0, busy}, 8'h00); rd_chk("idle_ack_id", IDP, 8'h00);

        src_req = 4'b1010; tick(1); src_req = '0;
        tick(3); rd_chk("pre_rst_id", IDP, 8'h81);
        reset_n = 1'b0;
        #1;
        chk("rst_async_int", {7'b0, interrupt}, 8'h00);
        chk("rst_async_busy", {7'b0, busy}, 8'h00);
        tick(2); reset_n = 1'b1;
        tick(5); chk("post_rst_int", {7'b0, interrupt}, 8'h00);
        rd_chk("post_rst_pend", PDP, 8'h00); rd_chk("post_rst_mask", MKP, 8'h0F);

        src_req = 4'b0001; tick(1); src_req = '0;
        tick(3); chk("retrig_g", {7'b0, interrupt}, 8'h01);
        src_req = 4'b0001; tick(1); src_req = '0;
        tick(4); chk("retrig_wait", {7'b0, busy}, 8'h01); rd_chk("retrig_pend", PDP, 8'h01);
        wr(AKP, 8'h00);
        tick(1); chk("retrig_regrant", {7'b0, interrupt}, 8'h01); rd_chk("retrig_id", IDP, 8'h80);
        tick(4); wr(AKP, 8'h00);
        chk("final_idle", {7'b0, busy}, 8'h00);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
